// File: rtl/alu_serial_core.sv
// Serial-load two-operand ALU: A/op[0] then B/op[1] arrive on successive
// opcode_valid cycles; add/sub/xor/xnor result is presented with a done pulse.
module alu_serial_core #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  opcode_valid,
   input  logic                  opcode,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  overflow,
   output logic                  done,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, GOT_A, EXEC, DONE} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH:0]   sum_q, sum_d;
   logic                  phase_q, phase_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH:0]   a_ext, b_ext;

   assign a_ext = {1'b0, a_q};
   assign b_ext = {1'b0, b_q};

   // EXEC spans two cycles: the first registers the wide sum, the second
   // moves it to the outputs, so done rises two edges after B is captured.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      sum_d      = sum_q;
      phase_d    = phase_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      busy_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (opcode_valid) begin
               a_d     = data;
               op_d[0] = opcode;
               state_d = GOT_A;
            end
         end
         GOT_A: begin
            if (opcode_valid) begin
               b_d     = data;
               op_d[1] = opcode;
               busy_d  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               busy_d  = 1'b1;
               unique case (op_q)
                  2'b00: sum_d = a_ext + b_ext;
                  2'b01: sum_d = a_ext - b_ext;
                  2'b10: sum_d = {1'b0, a_q ^ b_q};
                  2'b11: sum_d = {1'b0, ~(a_q ^ b_q)};
               endcase
            end else begin
               phase_d    = 1'b0;
               result_d   = sum_q[DATA_WIDTH-1:0];
               overflow_d = sum_q[DATA_WIDTH];
               done_d     = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (opcode_valid) begin
               a_d     = data;
               op_d[0] = opcode;
               state_d = GOT_A;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         sum_q      <= '0;
         phase_q    <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         sum_q      <= sum_d;
         phase_q    <= phase_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_alu_serial_core.sv
// Directed bench for alu_serial_core: hand-computed vectors, outputs sampled
// on the falling edge.
module tb_alu_serial_core;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       opcode_valid = 1'b0;
   logic       opcode = 1'b0;
   logic [7:0] data = '0;
   logic [7:0] result;
   logic       overflow;
   logic       done;
   logic       busy;

   int checks = 0;
   int failures = 0;

   alu_serial_core #(.DATA_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode_valid (opcode_valid),
      .opcode       (opcode),
      .data         (data),
      .result       (result),
      .overflow     (overflow),
      .done         (done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: present one valid beat, release it after the edge.
   task automatic send(input logic [7:0] d, input logic o);
      opcode_valid = 1'b1;
      data         = d;
      opcode       = o;
      @(posedge clk);
      @(negedge clk);
      opcode_valid = 1'b0;
   endtask

   // Called right after B was sent; ends at the falling edge of the done cycle.
   task automatic finish(input string tag, input logic [7:0] exp_r, input logic exp_ov);
      check({tag, "_exec1_busy"}, 32'(busy), 32'd1);
      check({tag, "_exec1_done"}, 32'(done), 32'd0);
      @(negedge clk);
      check({tag, "_exec2_busy"}, 32'(busy), 32'd1);
      check({tag, "_exec2_done"}, 32'(done), 32'd0);
      @(negedge clk);
      check({tag, "_done"},     32'(done),     32'd1);
      check({tag, "_busy_lo"},  32'(busy),     32'd0);
      check({tag, "_result"},   32'(result),   32'(exp_r));
      check({tag, "_overflow"}, 32'(overflow), 32'(exp_ov));
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic o0,
                         input logic [7:0] b, input logic o1,
                         input logic [7:0] exp_r, input logic exp_ov);
      send(a, o0);
      send(b, o1);
      finish(tag, exp_r, exp_ov);
      @(negedge clk);
      check({tag, "_pulse_end"}, 32'(done),   32'd0);
      check({tag, "_hold"},      32'(result), 32'(exp_r));
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_result",   32'(result),   32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_busy",     32'(busy),     32'd0);

      run_op("add_noovf", 8'd200, 1'b0, 8'd40,  1'b0, 8'd240,  1'b0);
      run_op("add_ovf",   8'd200, 1'b0, 8'd100, 1'b0, 8'h2C,   1'b1);
      run_op("sub_borrow", 8'd5,  1'b1, 8'd10,  1'b0, 8'hFB,   1'b1);
      run_op("sub_ok",    8'd10,  1'b1, 8'd5,   1'b0, 8'h05,   1'b0);
      run_op("xor",       8'hF0,  1'b0, 8'h3C,  1'b1, 8'hCC,   1'b0);
      run_op("xnor",      8'hF0,  1'b1, 8'h3C,  1'b1, 8'h33,   1'b0);

      // Reset for two cycles after A is loaded: transaction discarded.
      run_op("pre_rst", 8'd7, 1'b0, 8'd9, 1'b0, 8'd16, 1'b0);
      send(8'd99, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_result",   32'(result),   32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      check("mid_rst_done",     32'(done),     32'd0);
      check("mid_rst_busy",     32'(busy),     32'd0);
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_done", 32'(done), 32'd0);
      end
      run_op("post_rst", 8'd3, 1'b0, 8'd4, 1'b0, 8'd7, 1'b0);

      // opcode_valid held high through EXEC with different data: ignored.
      send(8'd50, 1'b0);
      opcode_valid = 1'b1;
      data         = 8'd20;
      opcode       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      data = 8'h77;
      opcode = 1'b1;
      check("hold_exec1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("hold_exec2_busy", 32'(busy), 32'd1);
      opcode_valid = 1'b0;
      @(negedge clk);
      check("hold_done",     32'(done),     32'd1);
      check("hold_result",   32'(result),   32'd70);
      check("hold_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      check("hold_idle_busy", 32'(busy), 32'd0);

      // Back-to-back: A of the next transaction presented in the DONE cycle.
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      finish("b2b_first", 8'd3, 1'b0);
      send(8'd8, 1'b1);
      check("b2b_got_a_done", 32'(done), 32'd0);
      check("b2b_got_a_busy", 32'(busy), 32'd0);
      send(8'd9, 1'b0);
      finish("b2b_second", 8'hFF, 1'b1);
      @(negedge clk);

      // Five idle cycles between A and B.
      send(8'h0F, 1'b0);
      repeat (5) begin
         @(negedge clk);
         check("gap_busy", 32'(busy), 32'd0);
         check("gap_done", 32'(done), 32'd0);
      end
      send(8'hF1, 1'b0);
      finish("gap", 8'h00, 1'b1);
      @(negedge clk);
      check("gap_pulse_end", 32'(done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
